axi_master_arbiter: RTL and testbench

AXI_MASTER_ARBITER -- requirements
Module: axi_master_arbiter

---
 rtl/axi_master_arbiter_pkg.sv | 38 +++
 rtl/axi_master_arbiter_channel.sv | 137 +++++++++++++
 rtl/axi_master_arbiter.sv | 101 ++++++++++
 tb/tb_axi_master_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_master_arbiter_pkg.sv
// Shared bus package for the axi_master arbiter slice.
// Holds the AXI response encoding, the per-channel arbiter FSM states,
// the legal requester-count bounds and the write payload layout.
package axi_master_arbiter_pkg;

  // Legal range for the number of requesters sharing one axi_master
  localparam int unsigned N_REQ_MIN = 2;
  localparam int unsigned N_REQ_MAX = 8;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_response_t;

  // Channel arbiter FSM: pick an owner, hand its request downstream, wait for done
  typedef enum logic [1:0] {
    CH_IDLE  = 2'b00,
    CH_ISSUE = 2'b01,
    CH_WAIT  = 2'b10
  } ch_state_t;

  // Buffered write request as seen by the write channel arbiter
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strobe;
  } write_payload_t;

  localparam int unsigned WR_PAYLOAD_W = $bits(write_payload_t);
  localparam int unsigned RD_PAYLOAD_W = ADDR_W;

endpackage

// File: rtl/axi_master_arbiter_channel.sv
// axi_channel_arbiter: one arbitration channel (write or read).
// Holds a pending flag and payload buffer per requester, selects an owner,
// and hands the owner's payload to the downstream port.
// Ports:
//   axi_ACLK, axi_ARESETN   clock, async active-low reset
//   start_i / payload_i     per-requester request pulse and payload
//   cts_o / done_o          per-requester clear-to-send and done pulse
//   m_start_o / m_payload_o request to the downstream axi_master port
//   m_cts_i / m_done_i      downstream clear-to-send and completion
// Build option: AXI_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration;
// otherwise the lowest pending index wins.
module axi_channel_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned PAYLOAD_W = 32
) (
  input  logic                             axi_ACLK,
  input  logic                             axi_ARESETN,
  input  logic [N_REQ-1:0]                 start_i,
  input  logic [N_REQ-1:0][PAYLOAD_W-1:0]  payload_i,
  output logic [N_REQ-1:0]                 cts_o,
  output logic [N_REQ-1:0]                 done_o,
  output logic                             m_start_o,
  output logic [PAYLOAD_W-1:0]             m_payload_o,
  input  logic                             m_cts_i,
  input  logic                             m_done_i
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  ch_state_t              state;
  logic [IDX_W-1:0]       owner;
  logic [N_REQ-1:0]       pending;
  logic [PAYLOAD_W-1:0]   pbuf [N_REQ];
  logic                   win_valid;
  logic [IDX_W-1:0]       win_idx;

`ifdef AXI_ARBITER_ROUND_ROBIN_EN
  // Index where the next search starts: one past the last owner
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W:0]         cand;

  // Scan downwards so the pending index closest to rr_ptr is kept
  always_comb begin
    win_valid = |pending;
    win_idx   = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N_REQ)) begin
        cand = cand - (IDX_W + 1)'(N_REQ);
      end
      if (pending[cand[IDX_W-1:0]]) begin
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Pointer advances past each newly granted owner
  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      rr_ptr <= '0;
    end else if (state == CH_IDLE && win_valid) begin
      if (win_idx == IDX_W'(N_REQ - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= win_idx + IDX_W'(1);
      end
    end
  end
`else
  // Fixed priority: lowest pending index wins
  always_comb begin
    win_valid = |pending;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (pending[k]) begin
        win_idx = IDX_W'(k);
      end
    end
  end
`endif

  // Pending flags, payload capture and channel FSM
  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      state   <= CH_IDLE;
      owner   <= '0;
      pending <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        pbuf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (start_i[i] && !pending[i]) begin
          pending[i] <= 1'b1;
          pbuf[i]    <= payload_i[i];
        end
      end
      case (state)
        CH_IDLE: begin
          if (win_valid) begin
            owner <= win_idx;
            state <= CH_ISSUE;
          end
        end
        CH_ISSUE: begin
          if (m_cts_i) begin
            state <= CH_WAIT;
          end
        end
        CH_WAIT: begin
          // Owner's flag is set here, so no capture can collide with this clear
          if (m_done_i) begin
            pending[owner] <= 1'b0;
            state          <= CH_IDLE;
          end
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

  assign cts_o       = ~pending;
  assign m_start_o   = (state == CH_ISSUE) && m_cts_i;
  assign m_payload_o = (state == CH_ISSUE) ? pbuf[owner] : '0;

  // Done is forwarded in the same cycle, only to the current owner
  always_comb begin
    done_o = '0;
    if (state == CH_WAIT && m_done_i) begin
      done_o[owner] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter: shares one axi_master request port among N_REQ
// requesters, with independent write and read arbitration.
// Ports:
//   axi_ACLK, axi_ARESETN                 clock, async active-low reset
//   req_write_*                           per-requester write request/status
//   req_read_*                            per-requester read request/status
//   req_read_data_o, req_*_response_o     broadcast, qualified by done pulses
//   write_* / read_*                      axi_master write and read ports
// Build option: AXI_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration
// (default build: fixed priority, lowest index wins).
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input  logic                           axi_ACLK,
  input  logic                           axi_ARESETN,
  input  logic [N_REQ-1:0]               req_write_start_i,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   req_write_address_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]   req_write_data_i,
  input  logic [N_REQ-1:0][STRB_W-1:0]   req_write_strobe_i,
  output logic [N_REQ-1:0]               req_write_cts_o,
  output logic [N_REQ-1:0]               req_write_done_o,
  input  logic [N_REQ-1:0]               req_read_start_i,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   req_read_address_i,
  output logic [N_REQ-1:0]               req_read_cts_o,
  output logic [N_REQ-1:0]               req_read_done_o,
  output logic [DATA_W-1:0]              req_read_data_o,
  output axi_response_t                  req_write_response_o,
  output axi_response_t                  req_read_response_o,
  output logic                           write_start_o,
  output logic [ADDR_W-1:0]              write_address_o,
  output logic [DATA_W-1:0]              write_data_o,
  output logic [STRB_W-1:0]              write_strobe_o,
  input  logic                           write_cts_i,
  input  logic                           write_done_i,
  input  axi_response_t                  write_response_i,
  output logic                           read_start_o,
  output logic [ADDR_W-1:0]              read_address_o,
  input  logic                           read_cts_i,
  input  logic                           read_done_i,
  input  logic [DATA_W-1:0]              read_data_i,
  input  axi_response_t                  read_response_i
);

  logic [N_REQ-1:0][WR_PAYLOAD_W-1:0] wr_payload;
  write_payload_t                     wr_out;

  // Pack each requester's write fields into one buffered payload
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      wr_payload[i] = write_payload_t'{
        address: req_write_address_i[i],
        data:    req_write_data_i[i],
        strobe:  req_write_strobe_i[i]
      };
    end
  end

  axi_channel_arbiter #(
    .N_REQ     (N_REQ),
    .PAYLOAD_W (WR_PAYLOAD_W)
  ) u_write_arb (
    .axi_ACLK    (axi_ACLK),
    .axi_ARESETN (axi_ARESETN),
    .start_i     (req_write_start_i),
    .payload_i   (wr_payload),
    .cts_o       (req_write_cts_o),
    .done_o      (req_write_done_o),
    .m_start_o   (write_start_o),
    .m_payload_o (wr_out),
    .m_cts_i     (write_cts_i),
    .m_done_i    (write_done_i)
  );

  assign write_address_o = wr_out.address;
  assign write_data_o    = wr_out.data;
  assign write_strobe_o  = wr_out.strobe;

  axi_channel_arbiter #(
    .N_REQ     (N_REQ),
    .PAYLOAD_W (RD_PAYLOAD_W)
  ) u_read_arb (
    .axi_ACLK    (axi_ACLK),
    .axi_ARESETN (axi_ARESETN),
    .start_i     (req_read_start_i),
    .payload_i   (req_read_address_i),
    .cts_o       (req_read_cts_o),
    .done_o      (req_read_done_o),
    .m_start_o   (read_start_o),
    .m_payload_o (read_address_o),
    .m_cts_i     (read_cts_i),
    .m_done_i    (read_done_i)
  );

  // Status is broadcast as-is; requesters qualify it with their done pulse
  assign req_read_data_o      = read_data_i;
  assign req_write_response_o = write_response_i;
  assign req_read_response_o  = read_response_i;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Self-checking bench for axi_master_arbiter (N_REQ = 3): directed steps
// followed by randomized rounds checked against a grant-order model.
module tb_axi_master_arbiter;
  import axi_master_arbiter_pkg::*;

  localparam int N = 3;

  logic                       clk;
  logic                       rst_n;
  logic [N-1:0]               req_write_start_i;
  logic [N-1:0][31:0]         req_write_address_i;
  logic [N-1:0][31:0]         req_write_data_i;
  logic [N-1:0][3:0]          req_write_strobe_i;
  logic [N-1:0]               req_write_cts_o;
  logic [N-1:0]               req_write_done_o;
  logic [N-1:0]               req_read_start_i;
  logic [N-1:0][31:0]         req_read_address_i;
  logic [N-1:0]               req_read_cts_o;
  logic [N-1:0]               req_read_done_o;
  logic [31:0]                req_read_data_o;
  axi_response_t              req_write_response_o;
  axi_response_t              req_read_response_o;
  logic                       write_start_o;
  logic [31:0]                write_address_o;
  logic [31:0]                write_data_o;
  logic [3:0]                 write_strobe_o;
  logic                       write_cts_i;
  logic                       write_done_i;
  axi_response_t              write_response_i;
  logic                       read_start_o;
  logic [31:0]                read_address_o;
  logic                       read_cts_i;
  logic                       read_done_i;
  logic [31:0]                read_data_i;
  axi_response_t              read_response_i;

  int errs;
  int checks;
  int wptr;
  int rptr;

  axi_master_arbiter #(.N_REQ(N)) dut (
    .axi_ACLK             (clk),
    .axi_ARESETN          (rst_n),
    .req_write_start_i    (req_write_start_i),
    .req_write_address_i  (req_write_address_i),
    .req_write_data_i     (req_write_data_i),
    .req_write_strobe_i   (req_write_strobe_i),
    .req_write_cts_o      (req_write_cts_o),
    .req_write_done_o     (req_write_done_o),
    .req_read_start_i     (req_read_start_i),
    .req_read_address_i   (req_read_address_i),
    .req_read_cts_o       (req_read_cts_o),
    .req_read_done_o      (req_read_done_o),
    .req_read_data_o      (req_read_data_o),
    .req_write_response_o (req_write_response_o),
    .req_read_response_o  (req_read_response_o),
    .write_start_o        (write_start_o),
    .write_address_o      (write_address_o),
    .write_data_o         (write_data_o),
    .write_strobe_o       (write_strobe_o),
    .write_cts_i          (write_cts_i),
    .write_done_i         (write_done_i),
    .write_response_i     (write_response_i),
    .read_start_o         (read_start_o),
    .read_address_o       (read_address_o),
    .read_cts_i           (read_cts_i),
    .read_done_i          (read_done_i),
    .read_data_i          (read_data_i),
    .read_response_i      (read_response_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_write_start_i   = '0;
    req_write_address_i = '0;
    req_write_data_i    = '0;
    req_write_strobe_i  = '0;
    req_read_start_i    = '0;
    req_read_address_i  = '0;
    write_cts_i         = 1'b0;
    write_done_i        = 1'b0;
    write_response_i    = AXI_OKAY;
    read_cts_i          = 1'b0;
    read_done_i         = 1'b0;
    read_data_i         = '0;
    read_response_i     = AXI_OKAY;
  endtask

  // Reference arbitration rule: which pending requester is granted next
  function automatic int pick(input logic [N-1:0] mask, input int ptr);
`ifdef AXI_ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (mask[k]) return k;
    end
`endif
    return -1;
  endfunction

  // All requests of a round start together, so the pending set only shrinks
  // and the grant order follows from the rule alone.
  task automatic run_round(input logic [N-1:0] wm, input logic [N-1:0] rm, input int cts_pct);
    logic [31:0]   wa [N];
    logic [31:0]   wd [N];
    logic [3:0]    ws [N];
    logic [31:0]   ra [N];
    int            wq[$];
    int            rq[$];
    logic [N-1:0]  m;
    logic [N-1:0]  oh;
    int            k;
    int            w_own, r_own, w_dly, r_dly, budget;
    bit            w_out, r_out, w_done, r_done;
    axi_response_t wresp, rresp;
    logic [31:0]   rdata;

    for (int i = 0; i < N; i++) begin
      wa[i] = $urandom; wd[i] = $urandom; ws[i] = 4'($urandom_range(15)); ra[i] = $urandom;
      req_write_address_i[i] = wa[i];
      req_write_data_i[i]    = wd[i];
      req_write_strobe_i[i]  = ws[i];
      req_read_address_i[i]  = ra[i];
    end
    req_write_start_i = wm;
    req_read_start_i  = rm;
    write_cts_i = 1'b0; read_cts_i = 1'b0;
    step();
    req_write_start_i = '0;
    req_read_start_i  = '0;

    m = wm;
    while (m != '0) begin k = pick(m, wptr); wq.push_back(k); m[k] = 1'b0; wptr = (k + 1) % N; end
    m = rm;
    while (m != '0) begin k = pick(m, rptr); rq.push_back(k); m[k] = 1'b0; rptr = (k + 1) % N; end

    w_out = 0; r_out = 0; w_dly = 0; r_dly = 0; w_own = 0; r_own = 0; budget = 0;
    while ((wq.size() != 0 || w_out || rq.size() != 0 || r_out) && budget < 400) begin
      budget++;
      write_cts_i = ($urandom_range(99) < cts_pct);
      read_cts_i  = ($urandom_range(99) < cts_pct);
      w_done = w_out ? (w_dly == 0) : ($urandom_range(9) == 0);
      r_done = r_out ? (r_dly == 0) : ($urandom_range(9) == 0);
      wresp = axi_response_t'(2'($urandom_range(3)));
      rresp = axi_response_t'(2'($urandom_range(3)));
      rdata = $urandom;
      write_done_i = w_done; write_response_i = wresp;
      read_done_i  = r_done; read_response_i  = rresp; read_data_i = rdata;
      #1;
      // Write channel
      if (w_out) chk("wr_payload_wait", {write_address_o, write_data_o, write_strobe_o}, 68'h0);
      if (w_out && w_done) begin
        oh = '0; oh[w_own] = 1'b1;
        chk("wr_done_owner", req_write_done_o, oh);
        chk("wr_resp", req_write_response_o, wresp);
        w_out = 0;
      end else begin
        chk("wr_done_quiet", req_write_done_o, '0);
        if (w_out) w_dly--;
      end
      if (!write_cts_i) begin
        chk("wr_start_no_cts", write_start_o, 1'b0);
      end else if (write_start_o) begin
        if (wq.size() == 0) begin
          chk("wr_start_extra", write_start_o, 1'b0);
        end else begin
          w_own = wq.pop_front();
          chk("wr_addr", write_address_o, wa[w_own]);
          chk("wr_data", write_data_o, wd[w_own]);
          chk("wr_strb", write_strobe_o, ws[w_own]);
          w_out = 1; w_dly = $urandom_range(3);
        end
      end
      // Read channel
      if (r_out) chk("rd_payload_wait", read_address_o, 32'h0);
      if (r_out && r_done) begin
        oh = '0; oh[r_own] = 1'b1;
        chk("rd_done_owner", req_read_done_o, oh);
        chk("rd_data", req_read_data_o, rdata);
        chk("rd_resp", req_read_response_o, rresp);
        r_out = 0;
      end else begin
        chk("rd_done_quiet", req_read_done_o, '0);
        if (r_out) r_dly--;
      end
      if (!read_cts_i) begin
        chk("rd_start_no_cts", read_start_o, 1'b0);
      end else if (read_start_o) begin
        if (rq.size() == 0) begin
          chk("rd_start_extra", read_start_o, 1'b0);
        end else begin
          r_own = rq.pop_front();
          chk("rd_addr", read_address_o, ra[r_own]);
          r_out = 1; r_dly = $urandom_range(3);
        end
      end
      step();
    end
    chk("round_in_budget", budget < 400, 1'b1);
    write_done_i = 1'b0; read_done_i = 1'b0; write_cts_i = 1'b0; read_cts_i = 1'b0;
    #1;
    chk("round_wr_cts_idle", req_write_cts_o, 3'b111);
    chk("round_rd_cts_idle", req_read_cts_o, 3'b111);
  endtask

  initial begin
    logic [N-1:0] wm, rm;
    errs = 0; checks = 0; wptr = 0; rptr = 0;
    idle_inputs();
    rst_n = 1'b0;
    write_cts_i = 1'b1; read_cts_i = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_wr_cts", req_write_cts_o, 3'b111);
    chk("rst_rd_cts", req_read_cts_o, 3'b111);
    chk("rst_wr_done", req_write_done_o, 3'b000);
    chk("rst_rd_done", req_read_done_o, 3'b000);
    chk("rst_wr_start", write_start_o, 1'b0);
    chk("rst_rd_start", read_start_o, 1'b0);
    chk("rst_wr_addr", write_address_o, 32'h0);
    rst_n = 1'b1;
    step();

    // Single write from requester 1
    write_cts_i = 1'b1;
    req_write_start_i = 3'b010;
    req_write_address_i[1] = 32'h0000_1000;
    req_write_data_i[1]    = 32'hDEAD_BEEF;
    req_write_strobe_i[1]  = 4'hF;
    chk("sw_cts_c0", req_write_cts_o, 3'b111);
    step();
    req_write_start_i = '0;
    wptr = (pick(3'b010, wptr) + 1) % N;
    chk("sw_cts_c1", req_write_cts_o, 3'b101);
    chk("sw_start_c1", write_start_o, 1'b0);
    step();
    chk("sw_start_c2", write_start_o, 1'b1);
    chk("sw_addr", write_address_o, 32'h0000_1000);
    chk("sw_data", write_data_o, 32'hDEAD_BEEF);
    chk("sw_strb", write_strobe_o, 4'hF);
    step();
    chk("sw_start_wait", write_start_o, 1'b0);
    chk("sw_addr_wait", write_address_o, 32'h0);
    write_done_i = 1'b1; write_response_i = AXI_SLVERR;
    #1;
    chk("sw_done", req_write_done_o, 3'b010);
    chk("sw_resp", req_write_response_o, AXI_SLVERR);
    step();
    write_done_i = 1'b0; write_response_i = AXI_OKAY;
    #1;
    chk("sw_cts_after", req_write_cts_o, 3'b111);
    chk("sw_done_after", req_write_done_o, 3'b000);

    // Done while idle is ignored
    write_done_i = 1'b1;
    #1;
    chk("idle_done_ignored", req_write_done_o, 3'b000);
    step();
    write_done_i = 1'b0;

    // Backpressure: cts low for five cycles in ISSUE
    write_cts_i = 1'b0;
    req_write_start_i = 3'b001;
    req_write_address_i[0] = 32'hA5A5_0004;
    req_write_data_i[0]    = 32'h0BAD_F00D;
    req_write_strobe_i[0]  = 4'h3;
    step();
    req_write_start_i = '0;
    wptr = (pick(3'b001, wptr) + 1) % N;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_start_low", write_start_o, 1'b0);
      chk("bp_addr_held", write_address_o, 32'hA5A5_0004);
      step();
    end
    write_cts_i = 1'b1;
    #1;
    chk("bp_start_on_cts", write_start_o, 1'b1);
    chk("bp_data", write_data_o, 32'h0BAD_F00D);
    step();
    write_done_i = 1'b1;
    #1;
    chk("bp_done", req_write_done_o, 3'b001);
    step();
    write_done_i = 1'b0;

    // Concurrent write (req 0) and read (req 1)
    write_cts_i = 1'b1; read_cts_i = 1'b1;
    req_write_start_i = 3'b001;
    req_write_address_i[0] = 32'h0000_2000;
    req_read_start_i = 3'b010;
    req_read_address_i[1] = 32'h0000_3000;
    step();
    req_write_start_i = '0; req_read_start_i = '0;
    wptr = (pick(3'b001, wptr) + 1) % N;
    rptr = (pick(3'b010, rptr) + 1) % N;
    step();
    chk("cc_wr_start", write_start_o, 1'b1);
    chk("cc_rd_start", read_start_o, 1'b1);
    chk("cc_rd_addr", read_address_o, 32'h0000_3000);
    step();
    write_done_i = 1'b1; read_done_i = 1'b1; read_data_i = 32'h1234_5678;
    read_response_i = AXI_OKAY;
    #1;
    chk("cc_rd_done", req_read_done_o, 3'b010);
    chk("cc_rd_data", req_read_data_o, 32'h1234_5678);
    chk("cc_wr_done", req_write_done_o, 3'b001);
    step();
    write_done_i = 1'b0; read_done_i = 1'b0;

    // All three requesters contend on both channels
    run_round(3'b111, 3'b111, 100);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      wm = 3'($urandom_range(7));
      rm = 3'($urandom_range(7));
      run_round(wm, rm, 60);
    end

    // Reset in WAIT with two write requests pending
    write_cts_i = 1'b1; read_cts_i = 1'b1;
    req_write_start_i = 3'b011;
    req_read_start_i  = 3'b100;
    step();
    req_write_start_i = '0; req_read_start_i = '0;
    step();
    step();
    chk("mr_wr_cts_busy", req_write_cts_o, 3'b100);
    rst_n = 1'b0;
    write_done_i = 1'b1; read_done_i = 1'b1;
    #1;
    chk("mr_wr_cts", req_write_cts_o, 3'b111);
    chk("mr_rd_cts", req_read_cts_o, 3'b111);
    chk("mr_wr_done", req_write_done_o, 3'b000);
    chk("mr_rd_done", req_read_done_o, 3'b000);
    chk("mr_wr_start", write_start_o, 1'b0);
    chk("mr_rd_start", read_start_o, 1'b0);
    step();
    rst_n = 1'b1;
    write_done_i = 1'b0; read_done_i = 1'b0;
    wptr = 0; rptr = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mr_wr_quiet", {write_start_o, req_write_done_o}, 4'h0);
      chk("mr_rd_quiet", {read_start_o, req_read_done_o}, 4'h0);
      chk("mr_wr_cts_after", req_write_cts_o, 3'b111);
    end

    // Arbitration still works after the mid-transaction reset
    run_round(3'b101, 3'b011, 70);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
